core_boot_loader: RTL and testbench
===================================

Name: core_boot_loader

Overview:
- Synthesizable, parametrised boot sequencer that replaces the hand-written boot sequence in the core benches.
- Loads data memory, then streams instruction, register, barrier-mask and PC packets to each of num_cores_p cores over the net_packet_s interface.
- Releases the memory port to the cores and monitors their stores for the pass/fail/code/done signature addresses.
- Sits between an image ROM and the core array; shared memory is muxed by mem_sel_o.

Parameters:
- num_cores_p, 1, cores to boot (1..10); core k is addressed by one-hot ID 10'b1<<k.
- instr_words_p, 1024, instruction words sent per core (0 allowed).
- reg_words_p, 2**rs_imm_size_gp, register packets sent per core (0 allowed).
- data_words_p, 1024, 32-bit data-memory words written (0 allowed).
- start_pc_p, 32'h5, net_data of the PC packet.
- barrier_mask_p, 32'h2, net_data of the BAR packet.
- barrier_addr_p, 10'd24, net_addr of the BAR and NULL packets.
- img_addr_w_p, 10, image address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start_i  in  1  one-cycle start pulse.
- busy_o  out  1  high from accepted start until RUN is entered.
- img_sel_o  out  2  image select: 0=data, 1=instr, 2=reg.
- img_addr_o  out  img_addr_w_p  image word address.
- img_data_i  in  40  image word; valid exactly 1 cycle after the address.
- net_packet_flat_o  out  $bits(net_packet_s)  packet to the cores, registered.
- mem_flat_o  out  $bits(mem_in_s)  loader's memory request.
- mem_addr_o  out  32  byte address of the loader's memory request.
- mem_ready_i  in  1  memory accepted the current write.
- mem_sel_o  out  1  0=loader owns memory, 1=cores own memory.
- mon_valid_i  in  1  core memory response valid.
- mon_addr_i  in  32  core memory address.
- mon_wdata_i  in  32  core write data.
- pass_o  out  1  one-cycle pulse on a C0FF_EEEE store.
- code_o  out  1  one-cycle pulse on a C0DE_C0DE store.
- done_o  out  1  sticky flag, set on a 600D_BEEF store.
- fail_o  out  1  sticky flag, set on a DEAD_DEAD store.
- status_data_o  out  32  write data of the last matched store.
- status_cycle_o  out  32  cycles spent in RUN at the last match.

Behaviour:
- Reset (reset==0): all outputs are 0, packet net_op=NULL, mem_sel_o=0, FSM in IDLE. Reset mid-operation aborts immediately.
- FSM states: IDLE, DMEM, INSTR, REG, BAR, PC, NEXT, RUN, HALT.
- IDLE: start_i goes to DMEM; core index k=0; word counter cleared.
- DMEM:
  - One write per word: valid=wen=yumi=1, byte_not_word=0, mem_addr_o=4*i, write_data=img_data_i[31:0].
  - The request is held until mem_ready_i is sampled high, then i advances.
  - After data_words_p accepts, go to INSTR. If data_words_p==0, go to INSTR without issuing a request.
- Image prefetch: img_addr_o leads the emitted word by 1 cycle. On state entry one bubble cycle is allowed; the emitted packet must correspond to the image word at its index.
- INSTR:
  - Emit one packet per cycle: ID=1<<k, net_op=INSTR, reserved=0, net_data={16'b0, img_data_i[15:0]}, net_addr=i.
  - After instr_words_p packets, go to REG.
- REG:
  - Emit net_op=REG, net_data=img_data_i[31:0], net_addr=img_data_i[37:32].
  - After reg_words_p packets, go to BAR.
- BAR: 1 cycle; emit net_op=BAR, net_data=barrier_mask_p, net_addr=barrier_addr_p.
- PC: 1 cycle; emit net_op=PC, net_data=start_pc_p, net_addr=0.
- NEXT:
  - If k<num_cores_p-1: k++, go to INSTR.
  - Otherwise go to RUN.
  - Every core is therefore fully loaded and started before the next core is loaded.
- RUN:
  - mem_sel_o=1; loader memory request has valid=0; packet net_op=NULL, net_data=32'hFFFFFFFE, net_addr=barrier_addr_p.
  - Cycle counter resets to 0 on entry and increments every RUN cycle, wrapping at 2^32.
- Monitor: active in RUN only. When mon_valid_i==1, decode mon_addr_i:
  - C0FF_EEEE: pulse pass_o.
  - C0DE_C0DE: pulse code_o.
  - 600D_BEEF: set done_o, go to HALT.
  - DEAD_DEAD: set fail_o, go to HALT.
  - Any match also latches status_data_o=mon_wdata_i and status_cycle_o=counter.
  - Other addresses: no effect.
- HALT: mem_sel_o stays 1; flags and status are held. start_i clears the flags and restarts the sequence at DMEM.
- start_i outside IDLE/HALT is ignored.
- Outputs emitted during loading are cleared to NULL the cycle after the last packet.

Decomposition:
- Shared package (definitions.sv): net_packet_s, net_op enum (NULL/INSTR/REG/BAR/PC), mem_in_s, instruction_s, and new localparams for the four signature addresses plus an img_sel enum.
- One sub-module: boot_status_monitor, containing the address decode, RUN cycle counter, pulses, sticky flags and status latches.

Test Plan:
- num_cores_p=1, data_words_p=4, instr_words_p=3, reg_words_p=2, mem_ready_i tied 1:
  - exactly 4 writes at byte addresses 0,4,8,12;
  - then INSTR net_addr 0,1,2 with image data;
  - then 2 REG packets, BAR (0x2, 24), PC (0x5, 0);
  - then NULL packets and mem_sel_o=1.
- mem_ready_i low for 3 cycles on write 2: that write is held stable for 4 cycles, with no skipped or duplicated address.
- num_cores_p=3: packet IDs are 001, 010, 100 in sequence, each followed by its own BAR and PC; busy_o falls when RUN is entered.
- In RUN: a store to C0FF_EEEE (data 0x12) gives one pass_o pulse and status_data_o=0x12; a following store to 600D_BEEF gives done_o=1 and HALT; further stores change nothing.
- Store to DEAD_DEAD: fail_o=1. Then start_i clears fail_o and a full reload restarts.
- reset asserted in the middle of INSTR: the next cycle shows NULL packet, mem_sel_o=0, busy_o=0; start_i afterwards reloads from data word 0.

Source files
------------

// File: rtl/core_boot_loader_pkg.sv
// Shared definitions for the core boot loader: network packet and memory
// request formats, packet opcodes, image select codes, FSM states and the
// store-address signatures that the cores use to report status.
package core_boot_loader_pkg;

  // Width of the register-file index carried in a REG packet.
  localparam int rs_imm_size_gp = 6;

  typedef enum logic [2:0] {
    OP_NULL  = 3'd0,
    OP_INSTR = 3'd1,
    OP_REG   = 3'd2,
    OP_BAR   = 3'd3,
    OP_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [4:0]  reserved;
    net_op_e     net_op;
    logic [9:0]  id;        // one-hot core select
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [15:0] imm;
  } instruction_s;

  typedef enum logic [1:0] {
    IMG_DATA  = 2'd0,
    IMG_INSTR = 2'd1,
    IMG_REG   = 2'd2
  } img_sel_e;

  typedef enum logic [3:0] {
    S_IDLE, S_DMEM, S_INSTR, S_REG, S_BAR, S_PC, S_NEXT, S_RUN, S_HALT
  } boot_state_e;

  localparam logic [31:0] SIG_PASS = 32'hC0FF_EEEE;
  localparam logic [31:0] SIG_CODE = 32'hC0DE_C0DE;
  localparam logic [31:0] SIG_DONE = 32'h600D_BEEF;
  localparam logic [31:0] SIG_FAIL = 32'hDEAD_DEAD;

endpackage

// File: rtl/core_boot_loader_status_monitor.sv
// boot_status_monitor: watches core stores while the cores run and decodes
// the signature addresses.
//   run_i          high while the loader is in RUN (monitor enable)
//   clear_i        clears the sticky done/fail flags (restart from HALT)
//   mon_*_i        core memory traffic
//   pass_o/code_o  one-cycle pulses; done_o/fail_o sticky flags
//   halt_o         combinational: a done/fail store is being seen now
//   status_*_o     write data / RUN cycle count of the last matched store
module boot_status_monitor
  import core_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        clear_i,
  input  logic        mon_valid_i,
  input  logic [31:0] mon_addr_i,
  input  logic [31:0] mon_wdata_i,
  output logic        pass_o,
  output logic        code_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        halt_o,
  output logic [31:0] status_data_o,
  output logic [31:0] status_cycle_o
);
  logic        vld;
  logic        hit_pass, hit_code, hit_done, hit_fail, hit_any;
  logic [31:0] cycle_q;

  assign vld      = run_i & mon_valid_i;
  assign hit_pass = vld & (mon_addr_i == SIG_PASS);
  assign hit_code = vld & (mon_addr_i == SIG_CODE);
  assign hit_done = vld & (mon_addr_i == SIG_DONE);
  assign hit_fail = vld & (mon_addr_i == SIG_FAIL);
  assign hit_any  = hit_pass | hit_code | hit_done | hit_fail;
  assign halt_o   = hit_done | hit_fail;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q        <= '0;
      pass_o         <= 1'b0;
      code_o         <= 1'b0;
      done_o         <= 1'b0;
      fail_o         <= 1'b0;
      status_data_o  <= '0;
      status_cycle_o <= '0;
    end else begin
      // Zero on every non-RUN cycle, so each RUN entry starts counting at 0.
      cycle_q <= run_i ? cycle_q + 32'd1 : '0;
      pass_o  <= hit_pass;
      code_o  <= hit_code;
      if (clear_i) begin
        done_o <= 1'b0;
        fail_o <= 1'b0;
      end else begin
        if (hit_done) done_o <= 1'b1;
        if (hit_fail) fail_o <= 1'b1;
      end
      if (hit_any) begin
        status_data_o  <= mon_wdata_i;
        status_cycle_o <= cycle_q;
      end
    end
  end
endmodule

// File: rtl/core_boot_loader.sv
// core_boot_loader: boot sequencer. Copies the data image into shared memory,
// then for each core in turn streams INSTR, REG, BAR and PC packets, then
// hands memory to the cores and watches their stores for status signatures.
//   start_i                 start pulse (accepted in IDLE or HALT)
//   busy_o                  loading in progress
//   img_sel_o/img_addr_o    image ROM request; img_data_i returns 1 cycle later
//   net_packet_flat_o       registered packet to the cores
//   mem_flat_o/mem_addr_o   loader write request, held until mem_ready_i
//   mem_sel_o               1 = cores own memory
//   mon_*_i                 core store traffic; pass/code/done/fail/status out
module core_boot_loader
  import core_boot_loader_pkg::*;
#(
  parameter int          num_cores_p    = 1,
  parameter int          instr_words_p  = 1024,
  parameter int          reg_words_p    = 2**rs_imm_size_gp,
  parameter int          data_words_p   = 1024,
  parameter logic [31:0] start_pc_p     = 32'h5,
  parameter logic [31:0] barrier_mask_p = 32'h2,
  parameter logic [9:0]  barrier_addr_p = 10'd24,
  parameter int          img_addr_w_p   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic [1:0]                 img_sel_o,
  output logic [img_addr_w_p-1:0]    img_addr_o,
  input  logic [39:0]                img_data_i,
  output logic [$bits(net_packet_s)-1:0] net_packet_flat_o,
  output logic [$bits(mem_in_s)-1:0] mem_flat_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ready_i,
  output logic                       mem_sel_o,
  input  logic                       mon_valid_i,
  input  logic [31:0]                mon_addr_i,
  input  logic [31:0]                mon_wdata_i,
  output logic                       pass_o,
  output logic                       code_o,
  output logic                       done_o,
  output logic                       fail_o,
  output logic [31:0]                status_data_o,
  output logic [31:0]                status_cycle_o
);
  localparam logic [31:0] DW_LAST   = 32'(data_words_p - 1);
  localparam logic [31:0] IW_LAST   = 32'(instr_words_p - 1);
  localparam logic [31:0] RW_LAST   = 32'(reg_words_p - 1);
  localparam logic [3:0]  CORE_LAST = 4'(num_cores_p - 1);

  boot_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // index of the word being emitted/written
  logic [3:0]  core_q, core_d;
  logic        primed_q, primed_d; // img_data_i holds word cnt_q this cycle
  logic        adv;                // current word is consumed this cycle
  logic        clear_flags, halt;
  img_sel_e    img_sel;
  net_packet_s pkt_q, pkt_d, run_pkt;
  mem_in_s     mem_req;
  logic [31:0] mem_addr;
  logic        unused_img_hi;

  assign unused_img_hi = ^img_data_i[39:38];

  always_comb begin
    run_pkt          = '0;
    run_pkt.net_op   = OP_NULL;
    run_pkt.net_data = 32'hFFFF_FFFE;
    run_pkt.net_addr = barrier_addr_p;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      core_q   <= '0;
      primed_q <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      core_q   <= core_d;
      primed_q <= primed_d;
      pkt_q    <= pkt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_d      = core_q;
    primed_d    = primed_q;
    pkt_d       = '0;
    adv         = 1'b1;
    clear_flags = 1'b0;
    img_sel     = IMG_DATA;
    mem_req     = '0;
    mem_addr    = '0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          clear_flags = 1'b1;
          state_d     = S_DMEM;
          cnt_d       = '0;
          core_d      = '0;
          primed_d    = 1'b0;
        end
      end
      S_DMEM: begin
        adv = mem_ready_i;
        if (data_words_p == 0) state_d = S_INSTR;
        else if (!primed_q) primed_d = 1'b1;
        else begin
          mem_req.valid      = 1'b1;
          mem_req.wen        = 1'b1;
          mem_req.yumi       = 1'b1;
          mem_req.write_data = img_data_i[31:0];
          mem_addr           = {cnt_q[29:0], 2'b00};
          if (mem_ready_i) begin
            if (cnt_q == DW_LAST) begin
              state_d  = S_INSTR;
              cnt_d    = '0;
              primed_d = 1'b0;
            end else cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_INSTR: begin
        img_sel = IMG_INSTR;
        if (instr_words_p == 0) state_d = S_REG;
        else if (!primed_q) primed_d = 1'b1;
        else begin
          pkt_d.id       = 10'b1 << core_q;
          pkt_d.net_op   = OP_INSTR;
          pkt_d.net_data = {16'b0, img_data_i[15:0]};
          pkt_d.net_addr = cnt_q[9:0];
          if (cnt_q == IW_LAST) begin
            state_d  = S_REG;
            cnt_d    = '0;
            primed_d = 1'b0;
          end else cnt_d = cnt_q + 32'd1;
        end
      end
      S_REG: begin
        img_sel = IMG_REG;
        if (reg_words_p == 0) state_d = S_BAR;
        else if (!primed_q) primed_d = 1'b1;
        else begin
          pkt_d.id       = 10'b1 << core_q;
          pkt_d.net_op   = OP_REG;
          pkt_d.net_data = img_data_i[31:0];
          pkt_d.net_addr = {4'b0, img_data_i[37:32]};
          if (cnt_q == RW_LAST) begin
            state_d  = S_BAR;
            cnt_d    = '0;
            primed_d = 1'b0;
          end else cnt_d = cnt_q + 32'd1;
        end
      end
      S_BAR: begin
        pkt_d.id       = 10'b1 << core_q;
        pkt_d.net_op   = OP_BAR;
        pkt_d.net_data = barrier_mask_p;
        pkt_d.net_addr = barrier_addr_p;
        state_d        = S_PC;
      end
      S_PC: begin
        pkt_d.id       = 10'b1 << core_q;
        pkt_d.net_op   = OP_PC;
        pkt_d.net_data = start_pc_p;
        state_d        = S_NEXT;
      end
      S_NEXT: begin
        if (core_q == CORE_LAST) state_d = S_RUN;
        else begin
          core_d  = core_q + 4'd1;
          state_d = S_INSTR;
        end
      end
      S_RUN: if (halt) state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Packet register already holds the RUN idle pattern on the first RUN cycle.
    if (state_d == S_RUN || state_d == S_HALT) pkt_d = run_pkt;
  end

  // Address runs one word ahead of the emitted index once primed, so a new
  // word arrives every cycle the current one is consumed.
  assign img_addr_o = img_addr_w_p'(cnt_q)
                    + {{(img_addr_w_p-1){1'b0}}, primed_q & adv};
  assign img_sel_o  = img_sel;
  assign net_packet_flat_o = pkt_q;
  assign mem_flat_o = mem_req;
  assign mem_addr_o = mem_addr;
  assign mem_sel_o  = (state_q == S_RUN) || (state_q == S_HALT);
  assign busy_o     = (state_q != S_IDLE) && !mem_sel_o;

  boot_status_monitor u_mon (
    .clk            (clk),
    .reset          (reset),
    .run_i          (state_q == S_RUN),
    .clear_i        (clear_flags),
    .mon_valid_i    (mon_valid_i),
    .mon_addr_i     (mon_addr_i),
    .mon_wdata_i    (mon_wdata_i),
    .pass_o         (pass_o),
    .code_o         (code_o),
    .done_o         (done_o),
    .fail_o         (fail_o),
    .halt_o         (halt),
    .status_data_o  (status_data_o),
    .status_cycle_o (status_cycle_o)
  );
endmodule

// File: tb/tb_core_boot_loader.sv
// Bench for core_boot_loader: random image contents, an expected packet/write
// stream built from the boot rules, and directed monitor scenarios.
module tb_core_boot_loader;
  import core_boot_loader_pkg::*;

  localparam int NC = 3, IW = 3, RW = 2, DW = 4;
  localparam int PKW = $bits(net_packet_s);
  localparam int MW  = $bits(mem_in_s);

  logic clk = 1'b0, reset = 1'b0, start_i = 1'b0;
  logic busy_o, mem_ready_i = 1'b1, mem_sel_o;
  logic [1:0] img_sel_o;
  logic [9:0] img_addr_o;
  logic [39:0] img_data_i = '0;
  logic [PKW-1:0] net_packet_flat_o;
  logic [MW-1:0] mem_flat_o;
  logic [31:0] mem_addr_o, mon_addr_i = '0, mon_wdata_i = '0;
  logic mon_valid_i = 1'b0;
  logic pass_o, code_o, done_o, fail_o;
  logic [31:0] status_data_o, status_cycle_o;

  int checks = 0, failures = 0, cyc = 0, run_start = 0;
  logic [39:0] rom_d [DW], rom_i [IW], rom_r [RW];
  net_packet_s exp_pk [$];

  core_boot_loader #(.num_cores_p(NC), .instr_words_p(IW), .reg_words_p(RW),
                     .data_words_p(DW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(busy_o),
    .img_sel_o(img_sel_o), .img_addr_o(img_addr_o), .img_data_i(img_data_i),
    .net_packet_flat_o(net_packet_flat_o), .mem_flat_o(mem_flat_o),
    .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i), .mem_sel_o(mem_sel_o),
    .mon_valid_i(mon_valid_i), .mon_addr_i(mon_addr_i), .mon_wdata_i(mon_wdata_i),
    .pass_o(pass_o), .code_o(code_o), .done_o(done_o), .fail_o(fail_o),
    .status_data_o(status_data_o), .status_cycle_o(status_cycle_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Image ROM: synchronous read, one cycle latency.
  always @(posedge clk) begin
    case (img_sel_o)
      2'd0: img_data_i <= (int'(img_addr_o) < DW) ? rom_d[int'(img_addr_o)] : 40'h0;
      2'd1: img_data_i <= (int'(img_addr_o) < IW) ? rom_i[int'(img_addr_o)] : 40'h0;
      2'd2: img_data_i <= (int'(img_addr_o) < RW) ? rom_r[int'(img_addr_o)] : 40'h0;
      default: img_data_i <= 40'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < DW; i++) rom_d[i] = {8'($urandom), $urandom};
    for (int i = 0; i < IW; i++) rom_i[i] = {8'($urandom), $urandom};
    for (int i = 0; i < RW; i++) rom_r[i] = {8'($urandom), $urandom};
  endtask

  // Expected packet stream: each core gets all of its packets before the next.
  task automatic build_expect();
    net_packet_s p;
    exp_pk.delete();
    for (int k = 0; k < NC; k++) begin
      for (int i = 0; i < IW; i++) begin
        p = '0; p.id = 10'b1 << k; p.net_op = OP_INSTR;
        p.net_data = {16'b0, rom_i[i][15:0]}; p.net_addr = 10'(i);
        exp_pk.push_back(p);
      end
      for (int i = 0; i < RW; i++) begin
        p = '0; p.id = 10'b1 << k; p.net_op = OP_REG;
        p.net_data = rom_r[i][31:0]; p.net_addr = {4'b0, rom_r[i][37:32]};
        exp_pk.push_back(p);
      end
      p = '0; p.id = 10'b1 << k; p.net_op = OP_BAR;
      p.net_data = 32'h2; p.net_addr = 10'd24;
      exp_pk.push_back(p);
      p = '0; p.id = 10'b1 << k; p.net_op = OP_PC;
      p.net_data = 32'h5; p.net_addr = 10'd0;
      exp_pk.push_back(p);
    end
  endtask

  // Start a load and follow it cycle by cycle. stall_word>=0 holds mem_ready_i
  // low for 3 cycles on that write; abort_pkts>0 returns after that many packets.
  task automatic do_load(input int stall_word, input int abort_pkts);
    int wr_idx = 0, pk_idx = 0, stall_cnt = 0;
    bit reached = 0;
    net_packet_s pk, run_pk;
    mem_in_s mr;
    build_expect();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    #1;
    chk("load_busy", 64'(busy_o), 64'd1);
    chk("load_flags_clr", 64'({done_o, fail_o}), 64'd0);
    for (int c = 0; c < 2000; c++) begin
      mem_ready_i = !(wr_idx == stall_word && stall_cnt < 3);
      #1;
      pk = net_packet_s'(net_packet_flat_o);
      mr = mem_in_s'(mem_flat_o);
      if (!busy_o) begin reached = 1; break; end
      chk("load_mem_sel", 64'(mem_sel_o), 64'd0);
      if (mr.valid) begin
        chk("wr_in_range", 64'(wr_idx < DW), 64'd1);
        if (wr_idx < DW) begin
          chk("wr_addr", 64'(mem_addr_o), 64'(4 * wr_idx));
          chk("wr_req", 64'({mr.wen, mr.yumi, mr.byte_not_word, mr.write_data}),
              64'({3'b110, rom_d[wr_idx][31:0]}));
        end
        if (wr_idx == stall_word) stall_cnt++;
        if (mem_ready_i) wr_idx++;
      end
      if (pk.net_op != OP_NULL) begin
        chk("pk_in_range", 64'(pk_idx < exp_pk.size()), 64'd1);
        if (pk_idx < exp_pk.size()) chk("packet", 64'(pk), 64'(exp_pk[pk_idx]));
        pk_idx++;
        if (abort_pkts > 0 && pk_idx == abort_pkts) return;
      end
      @(negedge clk);
    end
    run_pk = '0; run_pk.net_op = OP_NULL;
    run_pk.net_data = 32'hFFFF_FFFE; run_pk.net_addr = 10'd24;
    chk("load_reached_run", 64'(reached), 64'd1);
    chk("wr_total", 64'(wr_idx), 64'(DW));
    chk("pk_total", 64'(pk_idx), 64'(exp_pk.size()));
    chk("run_mem_sel", 64'(mem_sel_o), 64'd1);
    chk("run_null_pkt", 64'(net_packet_flat_o), 64'(run_pk));
    chk("run_mem_idle", 64'(mem_flat_o), 64'd0);
    if (stall_word >= 0) chk("stall_hold", 64'(stall_cnt), 64'd4);
    run_start = cyc;
    mem_ready_i = 1'b1;
  endtask

  // One-cycle core store; 'at' is the RUN cycle index of the store.
  task automatic store(input logic [31:0] a, input logic [31:0] d, output int at);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    @(negedge clk);
    mon_valid_i = 1'b1; mon_addr_i = a; mon_wdata_i = d;
    at = cyc - run_start;
    @(negedge clk);
    mon_valid_i = 1'b0; mon_addr_i = $urandom; mon_wdata_i = $urandom;
    #1;
  endtask

  initial begin
    int at, at_done;
    logic [31:0] r, r_done;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pkt", 64'(net_packet_flat_o), 64'd0);
    chk("rst_mem", 64'({mem_flat_o, mem_addr_o}), 64'd0);
    chk("rst_ctl", 64'({busy_o, mem_sel_o, img_sel_o, img_addr_o}), 64'd0);
    chk("rst_flags", 64'({pass_o, code_o, done_o, fail_o}), 64'd0);
    chk("rst_status", 64'({status_data_o, status_cycle_o}), 64'd0);
    reset = 1'b1;

    // Plain load, then monitor traffic.
    fill_rom();
    do_load(-1, 0);
    store($urandom | 32'h1, $urandom, at);
    chk("other_addr", 64'({pass_o, code_o, done_o, fail_o, status_data_o}), 64'd0);
    store(SIG_PASS, 32'h12, at);
    chk("pass_pulse", 64'(pass_o), 64'd1);
    chk("pass_data", 64'(status_data_o), 64'h12);
    chk("pass_cycle", 64'(status_cycle_o), 64'(at));
    @(negedge clk); #1;
    chk("pass_one_cycle", 64'(pass_o), 64'd0);
    r = $urandom;
    store(SIG_CODE, r, at);
    chk("code_pulse", 64'({code_o, pass_o}), 64'b10);
    chk("code_data", 64'(status_data_o), 64'(r));
    r_done = $urandom;
    store(SIG_DONE, r_done, at_done);
    chk("done_flag", 64'({done_o, fail_o}), 64'b10);
    chk("done_halt", 64'({busy_o, mem_sel_o}), 64'b01);
    chk("done_status", 64'({status_data_o, status_cycle_o}), {r_done, 32'(at_done)});
    store(SIG_FAIL, $urandom, at);
    store(SIG_PASS, $urandom, at);
    chk("halt_ignores", 64'({pass_o, done_o, fail_o}), 64'b010);
    chk("halt_status", 64'({status_data_o, status_cycle_o}), {r_done, 32'(at_done)});

    // Restart from HALT with a stalled write, then a fail signature.
    fill_rom();
    do_load(2, 0);
    r = $urandom;
    store(SIG_FAIL, r, at);
    chk("fail_flag", 64'({done_o, fail_o}), 64'b01);
    chk("fail_status", 64'({status_data_o, status_cycle_o}), {r, 32'(at)});

    // Restart clears fail; reset in the middle of INSTR aborts.
    fill_rom();
    do_load(-1, 2);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("abort_pkt", 64'(net_packet_flat_o), 64'd0);
    chk("abort_ctl", 64'({busy_o, mem_sel_o, fail_o}), 64'd0);
    reset = 1'b1;
    fill_rom();
    do_load(-1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
